// File: rtl/counter_cmd_driver.sv
// Command sequencer for an 8-bit loadable up/down counter: buffers LOAD/UP/DOWN
// commands in a small circular FIFO and replays each one on the counter pins cycle by cycle.
module counter_cmd_driver #(
    parameter int DATA_W     = 8,
    parameter int LEN_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [1:0]                    cmd_op,
    input  logic [DATA_W-1:0]             cmd_data,
    input  logic [LEN_W-1:0]              cmd_len,
    output logic                          load_en,
    output logic                          count_en,
    output logic [DATA_W-1:0]             data,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int              AW         = $clog2(FIFO_DEPTH);
    localparam int              EW         = 2 + DATA_W + LEN_W;
    localparam logic [AW:0]     FULL_LEVEL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        OP_ILLEGAL = 2'b00,
        OP_LOAD    = 2'b01,
        OP_UP      = 2'b10,
        OP_DOWN    = 2'b11
    } op_e;

    typedef enum logic {S_IDLE, S_RUN} state_e;

    logic [EW-1:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       level_q, level_d;
    state_e            state_q;
    logic [LEN_W-1:0]  remain_q;
    logic              load_en_q, count_en_q, busy_q, done_q, err_q;
    logic [DATA_W-1:0] data_q;

    logic              accept, push, pop, fifo_empty, last_cycle, run_next;
    logic [EW-1:0]     head_word;
    op_e               head_op;
    logic [DATA_W-1:0] head_data;
    logic [LEN_W-1:0]  head_len;

    assign cmd_ready  = (level_q != FULL_LEVEL);
    assign accept     = cmd_valid && cmd_ready;
    assign push       = accept && (cmd_op != OP_ILLEGAL);
    assign fifo_empty = (level_q == '0);
    assign last_cycle = (state_q == S_RUN) && (remain_q == LEN_W'(1));
    // The next command is taken on the final drive cycle so back-to-back commands have no gap.
    assign pop        = !fifo_empty && ((state_q == S_IDLE) || last_cycle);
    assign run_next   = pop || ((state_q == S_RUN) && !last_cycle);

    assign head_word = mem_q[rd_ptr_q];
    assign head_op   = op_e'(head_word[EW-1 -: 2]);
    assign head_data = head_word[LEN_W +: DATA_W];
    assign head_len  = head_word[LEN_W-1:0];

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    // NOTE: payload storage is not reset; clearing the pointers and level is what empties the FIFO.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_op, cmd_data, cmd_len};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_d;
            err_q   <= err_q || (accept && (cmd_op == OP_ILLEGAL));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            remain_q   <= '0;
            load_en_q  <= 1'b0;
            count_en_q <= 1'b0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= last_cycle;
            busy_q <= run_next || (level_d != '0);
            if (pop) begin
                state_q    <= S_RUN;
                remain_q   <= (head_len == '0) ? LEN_W'(1) : head_len;
                load_en_q  <= (head_op == OP_LOAD);
                count_en_q <= (head_op == OP_UP);
                data_q     <= (head_op == OP_LOAD) ? head_data : '0;
            end else if (run_next) begin
                remain_q <= remain_q - LEN_W'(1);
            end else begin
                state_q    <= S_IDLE;
                remain_q   <= '0;
                load_en_q  <= 1'b0;
                count_en_q <= 1'b0;
                data_q     <= '0;
            end
        end
    end

    assign load_en  = load_en_q;
    assign count_en = count_en_q;
    assign data     = data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign level    = level_q;

endmodule

// File: tb/tb_counter_cmd_driver.sv
// Bench for counter_cmd_driver: a done-triggered scoreboard checks each command's pin
// window in push order, while scenario tasks check timing, flow control, err and reset.
module tb_counter_cmd_driver;

    typedef struct packed {
        logic [1:0] op;
        logic [7:0] data;
        logic [7:0] len;
    } cmd_t;

    localparam logic [1:0] OP_BAD = 2'b00, OP_LOAD = 2'b01, OP_UP = 2'b10, OP_DOWN = 2'b11;

    logic       clk, reset, cmd_valid, cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data, cmd_len;
    logic       load_en, count_en, busy, done, err;
    logic [7:0] data;
    logic [2:0] level;

    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   cyc = 0;
    int   done_total = 0;
    bit   mon_en = 0;
    logic [7:0] cnt_model;

    cmd_t       exp_q[$];
    logic [9:0] hist_q[$];
    int         done_cyc_q[$];
    logic [7:0] done_cnt_q[$];

    counter_cmd_driver #(.DATA_W(8), .LEN_W(8), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_len(cmd_len),
        .load_en(load_en), .count_en(count_en), .data(data),
        .busy(busy), .done(done), .err(err), .level(level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Model of the counter being driven; it free-runs down while the driver is idle.
    always @(posedge clk or negedge reset) begin
        if (!reset)        cnt_model <= 8'h00;
        else if (load_en)  cnt_model <= data;
        else if (count_en) cnt_model <= cnt_model + 8'h01;
        else               cnt_model <= cnt_model - 8'h01;
    end

    function automatic logic [9:0] drive_word(input cmd_t c);
        case (c.op)
            OP_LOAD: return {2'b10, c.data};
            OP_UP:   return {2'b01, 8'h00};
            default: return 10'h000;
        endcase
    endfunction

    cmd_t       mon_c;
    int         mon_n, mon_bad;
    logic [9:0] mon_got;

    // On each done pulse, the previous max(len,1) sampled pin words must be the oldest pending command.
    always @(negedge clk) begin
        if (reset && mon_en) begin
            if (done) begin
                done_total++;
                done_cyc_q.push_back(cyc);
                done_cnt_q.push_back(cnt_model);
                total_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL sb_unexpected_done: got done at cycle %0d, required no pending command", cyc);
                end else begin
                    mon_c   = exp_q.pop_front();
                    mon_n   = (mon_c.len == 8'h00) ? 1 : int'(mon_c.len);
                    mon_bad = -1;
                    mon_got = 10'h000;
                    if (hist_q.size() < mon_n) mon_bad = 0;
                    else begin
                        for (int k = 0; k < mon_n; k++) begin
                            if (mon_bad < 0 && hist_q[hist_q.size() - mon_n + k] !== drive_word(mon_c)) begin
                                mon_bad = k;
                                mon_got = hist_q[hist_q.size() - mon_n + k];
                            end
                        end
                    end
                    if (mon_bad < 0) pass_cnt++;
                    else $display("FAIL sb_drive: op %b cycle %0d got pins %h, required %h",
                                  mon_c.op, mon_bad, mon_got, drive_word(mon_c));
                end
            end
            hist_q.push_back({load_en, count_en, data});
            if (hist_q.size() > 64) void'(hist_q.pop_front());
        end
    end

    task automatic push_cmd(input logic [1:0] op, input logic [7:0] d, input logic [7:0] len,
                            output int acc);
        int   guard;
        cmd_t c;
        guard     = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        cmd_len   = len;
        while (!cmd_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            total_cnt++;
            $display("FAIL push_timeout: got cmd_ready=0 for %0d cycles, required 1", guard);
            acc = -1;
        end else begin
            acc = cyc + 1;
            if (op != OP_BAD) begin
                c.op = op; c.data = d; c.len = len;
                exp_q.push_back(c);
            end
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int guard;
        guard = 0;
        while ((busy || done) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        total_cnt++;
        if (guard >= 300) $display("FAIL %s_idle_timeout: got busy after %0d cycles, required idle", name, guard);
        else pass_cnt++;
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL %s_pending: got %0d commands not executed, required 0", name, exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_reset_state(input string name);
        total_cnt++;
        if ({load_en, count_en, data} !== 10'h000)
            $display("FAIL %s_pins: got %h, required 000", name, {load_en, count_en, data});
        else pass_cnt++;
        total_cnt++;
        if ({busy, done, err, level, cmd_ready} !== 7'b000_000_1)
            $display("FAIL %s_status: got busy/done/err/level/ready %b, required 0000001", name,
                     {busy, done, err, level, cmd_ready});
        else pass_cnt++;
    endtask

    task automatic test_single_load();
        int acc;
        done_cyc_q.delete();
        push_cmd(OP_LOAD, 8'h0F, 8'd1, acc);
        total_cnt++;
        if ({load_en, level, busy} !== {1'b0, 3'd1, 1'b1})
            $display("FAIL sl_accepted: got load_en/level/busy %b, required 0_001_1", {load_en, level, busy});
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({load_en, count_en, data, done} !== {2'b10, 8'h0F, 1'b0})
            $display("FAIL sl_drive: got %h, required %h", {load_en, count_en, data, done}, {2'b10, 8'h0F, 1'b0});
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({load_en, data, done, busy} !== {1'b0, 8'h00, 1'b1, 1'b0})
            $display("FAIL sl_done: got load_en/data/done/busy %h, required %h", {load_en, data, done, busy}, {1'b0, 8'h00, 2'b10});
        else pass_cnt++;
        total_cnt++;
        if (cnt_model !== 8'h0F) $display("FAIL sl_counter: got %h, required 0f", cnt_model);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (done !== 1'b0) $display("FAIL sl_done_width: got done=%b, required 0", done);
        else pass_cnt++;
        wait_idle("sl");
    endtask

    task automatic test_back_to_back();
        int         a0, a1, a2, first;
        int         exp_rel[3];
        logic [7:0] exp_cnt[3];
        exp_rel = '{3, 7, 10};
        exp_cnt = '{8'hF0, 8'hEC, 8'hEF};
        done_cyc_q.delete();
        done_cnt_q.delete();
        push_cmd(OP_LOAD, 8'hF0, 8'd2, a0);
        push_cmd(OP_DOWN, 8'h00, 8'd4, a1);
        push_cmd(OP_UP,   8'h00, 8'd3, a2);
        first = a0 + 1;
        wait_idle("b2b");
        total_cnt++;
        if (done_cyc_q.size() != 3) $display("FAIL b2b_done_count: got %0d, required 3", done_cyc_q.size());
        else begin
            pass_cnt++;
            for (int i = 0; i < 3; i++) begin
                total_cnt++;
                if (done_cyc_q[i] - first + 1 != exp_rel[i])
                    $display("FAIL b2b_done_pos%0d: got cycle %0d, required %0d", i, done_cyc_q[i] - first + 1, exp_rel[i]);
                else pass_cnt++;
                total_cnt++;
                if (done_cnt_q[i] !== exp_cnt[i])
                    $display("FAIL b2b_counter%0d: got %h, required %h", i, done_cnt_q[i], exp_cnt[i]);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_full_buffer();
        int         acc[5];
        logic [1:0] ops[5];
        int         ready_bad, max_lvl, d0;
        ops       = '{OP_UP, OP_DOWN, OP_LOAD, OP_UP, OP_DOWN};
        ready_bad = 0;
        max_lvl   = 0;
        d0        = done_total;
        for (int i = 0; i < 5; i++) begin
            push_cmd(ops[i], 8'h55, 8'd8, acc[i]);
            if (int'(level) > max_lvl) max_lvl = int'(level);
        end
        total_cnt++;
        if (acc[4] != acc[0] + 4) $display("FAIL fb_accept5: got edge %0d, required %0d", acc[4], acc[0] + 4);
        else pass_cnt++;
        total_cnt++;
        if ({level, cmd_ready} !== {3'd4, 1'b0})
            $display("FAIL fb_full: got level/ready %b, required 100_0", {level, cmd_ready});
        else pass_cnt++;
        while (cyc < acc[0] + 9) begin
            if (cmd_ready) ready_bad++;
            if (int'(level) > max_lvl) max_lvl = int'(level);
            @(negedge clk);
        end
        total_cnt++;
        if (ready_bad != 0) $display("FAIL fb_ready_low: got %0d ready cycles while full, required 0", ready_bad);
        else pass_cnt++;
        total_cnt++;
        if ({level, cmd_ready} !== {3'd3, 1'b1})
            $display("FAIL fb_slot_freed: got level/ready %b, required 011_1", {level, cmd_ready});
        else pass_cnt++;
        wait_idle("fb");
        total_cnt++;
        if (max_lvl > 4) $display("FAIL fb_max_level: got %0d, required <= 4", max_lvl);
        else pass_cnt++;
        total_cnt++;
        if (done_total - d0 != 5) $display("FAIL fb_done_count: got %0d, required 5", done_total - d0);
        else pass_cnt++;
    endtask

    task automatic test_len0_illegal();
        int a0, a1, a2;
        done_cyc_q.delete();
        push_cmd(OP_UP, 8'h00, 8'd0, a0);
        push_cmd(OP_BAD, 8'hAA, 8'd5, a1);
        total_cnt++;
        if (err !== 1'b1) $display("FAIL il_err_set: got %b, required 1", err);
        else pass_cnt++;
        push_cmd(OP_DOWN, 8'h00, 8'd1, a2);
        wait_idle("il");
        total_cnt++;
        if (done_cyc_q.size() != 2) $display("FAIL il_done_count: got %0d, required 2", done_cyc_q.size());
        else begin
            pass_cnt++;
            total_cnt++;
            if (done_cyc_q[0] != a0 + 2 || done_cyc_q[1] != a2 + 2)
                $display("FAIL il_done_pos: got %0d,%0d, required %0d,%0d", done_cyc_q[0], done_cyc_q[1], a0 + 2, a2 + 2);
            else pass_cnt++;
        end
        total_cnt++;
        if (err !== 1'b1) $display("FAIL il_err_sticky: got %b, required 1", err);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        int acc[20];
        int bad_acc, bad_done;
        bad_acc  = 0;
        bad_done = 0;
        done_cyc_q.delete();
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) push_cmd(OP_LOAD, 8'(i * 13 + 1), 8'd1, acc[i]);
            else            push_cmd(OP_UP,   8'h00,          8'd1, acc[i]);
            if (acc[i] != acc[0] + i) bad_acc++;
        end
        wait_idle("wr");
        total_cnt++;
        if (bad_acc != 0) $display("FAIL wr_accept: got %0d stalled pushes, required 0", bad_acc);
        else pass_cnt++;
        total_cnt++;
        if (done_cyc_q.size() != 20) $display("FAIL wr_done_count: got %0d, required 20", done_cyc_q.size());
        else begin
            pass_cnt++;
            for (int i = 0; i < 20; i++) if (done_cyc_q[i] != acc[0] + 2 + i) bad_done++;
            total_cnt++;
            if (bad_done != 0) $display("FAIL wr_no_bubble: got %0d late done pulses, required 0", bad_done);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_run();
        int a0, d0, bad;
        bad = 0;
        push_cmd(OP_UP, 8'h00, 8'd10, a0);
        repeat (2) @(negedge clk);
        total_cnt++;
        if (count_en !== 1'b1) $display("FAIL rm_running: got count_en=%b, required 1", count_en);
        else pass_cnt++;
        #2 reset = 1'b0;
        #1 test_reset_state("rm_async");
        exp_q.delete();
        hist_q.delete();
        d0 = done_total;
        @(negedge clk);
        total_cnt++;
        if ({done, busy, level} !== 5'b0) $display("FAIL rm_held: got done/busy/level %b, required 00000", {done, busy, level});
        else pass_cnt++;
        reset = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (done || busy || load_en || count_en) bad++;
        end
        total_cnt++;
        if (bad != 0 || done_total != d0)
            $display("FAIL rm_idle_after: got %0d active cycles and %0d done pulses, required 0 and 0", bad, done_total - d0);
        else pass_cnt++;
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = 8'h00;
        cmd_len   = 8'h00;
        #2 reset = 1'b0;
        #1 test_reset_state("por");
        repeat (2) @(negedge clk);
        reset  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        test_single_load();
        test_back_to_back();
        test_full_buffer();
        test_len0_illegal();
        test_wrap();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
